click_sync_rx: RTL and testbench
================================

# click_sync_rx

Clocked receiver at the far end of a two-phase bundled-data click pipeline. It takes transition-signalled requests (`inR`) with bundled data, already matched by the pipeline's delay elements, into the `clk` domain. Captured words go into a small FIFO and are presented on a valid/ready interface. The block returns two-phase acknowledges (`inA`) to the asynchronous sender and withholds them while the FIFO is full.

## Interface
- `DATA_WIDTH`, 32, width of bundled data word
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `clk`  in  1  system clock; all state updates on rising edge
- `rstn`  in  1  reset, synchronous, active-low; resets all state when sampled low on a rising `clk` edge
- `inR`  in  1  two-phase request from async sender; each transition means one new word
- `inA`  out  1  two-phase acknowledge; one transition per captured word
- `in_data`  in  DATA_WIDTH  bundled data; sender holds it stable from the `inR` transition until the matching `inA` transition
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts `out_data` this cycle
- `out_data`  out  DATA_WIDTH  FIFO head word
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- `inR` passes through an N-stage flop synchronizer (N=2 by default) to give `inR_s`. Only `inR_s` is used. `in_data` is never synchronized; the bundled-data contract guarantees it is stable.
- Pending request: `inR_s != inA`.
- Read event: `rd = out_valid & out_ready`. Pops the head and advances `rd_ptr`.
- Write event: `wr = pending & (count < DEPTH | rd)`. Writes `in_data` to `mem[wr_ptr]`, advances `wr_ptr`, and toggles `inA` on the same edge.
- Because `inA` toggles on the write edge, `pending` clears on the next cycle. Exactly one word is captured per `inR` transition.
- `count` update: +1 on write only, −1 on read only, unchanged when both occur or neither occurs.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally at DEPTH.
- `out_valid = (count != 0)`.
- `out_data = mem[rd_ptr]`, combinational read.
- Full (`count == DEPTH`) with no read: `pending` stays high and `inA` does not toggle. The sender stalls with `in_data` held.
- Empty: `out_valid = 0`. An `out_ready` assertion is ignored and `count` does not underflow.
- Reset mid-transfer: the FIFO contents are discarded and `inA` returns to 0. The async sender shares `rstn` and must also return `inR` to 0, so no spurious pending request appears after reset.

## Timing
- Reset values: `inA=0`, `out_valid=0`, `count=0`, all `mem` entries 0 (so `out_data=0`), pointers 0, synchronizer flops 0.
- Latency with the FIFO not full: an `inR` transition before edge k gives `inR_s` updated after edge k+N−1. The write and the `inA` toggle happen on edge k+N, and `out_valid` rises after edge k+N. Default total: 2 cycles to `inR_s`, 3 edges to `out_valid`.
- Throughput: at most one word per N+1 cycles plus the sender's async response time.
- Read-to-free: when full, a read on edge j lets the stalled write happen on the same edge j. The FIFO stays at DEPTH and `inA` toggles.
- Timing constraint for the integrator: the sender's delay chain must cover `in_data` settling before `inR`. The first synchronizer flop is the only metastability-exposed flop.

## Configuration
- `CLICK_SYNC_RX_SYNC3_EN`:
  - Defined: N=3 synchronizer stages. Latency from `inR` transition to `out_valid` is 4 edges; throughput is one word per 4 cycles.
  - Undefined: N=2, timing as above. All other behaviour is identical.

## Test plan
- Reset: hold `rstn=0` for 3 cycles with `inR` toggling → `inA=0`, `out_valid=0`, `count=0`, `out_data=0` throughout and after release.
- Single word:
  - Stimulus: toggle `inR` 0→1 with `in_data=0xA5A5_0001`, `out_ready=0`.
  - Required: `inA` 0→1 and `out_valid=1` after the 3rd edge, `count=1`, `out_data=0xA5A5_0001`.
  - Then assert `out_ready` for 1 cycle → `count=0`, `out_valid=0`.
- Fill/stall:
  - Stimulus: `out_ready=0`; sender answers each `inA` with a new `inR` toggle, data 1..5.
  - Required: exactly 4 `inA` toggles, `count=4`, 5th request pending with `inA` frozen.
  - Then one read → word 1 out, word 5 written on the same edge, `inA` toggles, `count` stays 4.
- Wrap-around: stream 10 words with `out_ready=1` continuously → output order 1..10 intact across pointer wrap, `count` ≤1, no lost or duplicated words.
- Simultaneous:
  - Stimulus: `count=2`, a pending write and a read on the same edge.
  - Required: `count` stays 2, head advances, new word at tail.
- Reset mid-operation: assert `rstn=0` while `count=3` and a request is pending → next cycle `count=0`, `inA=0`, `out_valid=0`. After release, a fresh `inR` 0→1 captures correctly.

Source files
------------

// File: rtl/click_sync_rx_if.sv
// Bundle of the async click-side handshake and the clocked valid/ready output bus
// of click_sync_rx. The receiver connects through the slave modport.
interface click_sync_rx_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  inR;
    logic                  inA;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CNT_W-1:0]      count;

    modport master (
        output inR,
        output in_data,
        output out_ready,
        input  inA,
        input  out_valid,
        input  out_data,
        input  count
    );

    modport slave (
        input  inR,
        input  in_data,
        input  out_ready,
        output inA,
        output out_valid,
        output out_data,
        output count
    );
endinterface

// File: rtl/click_sync_rx.sv
// Two-phase bundled-data receiver: synchronizes inR, captures words into a FIFO and
// returns inA per captured word. Define CLICK_SYNC_RX_SYNC3_EN for a 3-stage synchronizer.
module click_sync_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic           clk,
    input  logic           rstn,
    click_sync_rx_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef CLICK_SYNC_RX_SYNC3_EN
    localparam int SYNC_N = 3;
`else
    localparam int SYNC_N = 2;
`endif
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [SYNC_N-1:0]     sync_q, sync_d;
    logic                  inA_q, inA_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic inR_s;
    logic pending_s;
    logic full_s;
    logic rd_s;
    logic wr_s;

    // Handshake decode: a read frees a slot on the same edge, so a full FIFO can still accept.
    always_comb begin
        inR_s     = sync_q[SYNC_N-1];
        pending_s = inR_s ^ inA_q;
        full_s    = (count_q == CNT_FULL);
        rd_s      = out_valid_q & bus.out_ready;
        if (pending_s && (!full_s || rd_s)) begin
            wr_s = 1'b1;
        end else begin
            wr_s = 1'b0;
        end
    end

    // Next-state for synchronizer, pointers, occupancy, acknowledge and storage.
    always_comb begin
        sync_d   = {sync_q[SYNC_N-2:0], bus.inR};
        inA_d    = inA_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (wr_s) begin
            mem_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
            inA_d           = ~inA_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_s, rd_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        out_valid_d = (count_d != {CNT_W{1'b0}});
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q      <= {SYNC_N{1'b0}};
            inA_q       <= 1'b0;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            sync_q      <= sync_d;
            inA_q       <= inA_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.inA       = inA_q;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = count_q;
    assign bus.out_data  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_click_sync_rx.sv
// Bench for click_sync_rx: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_click_sync_rx;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
`ifdef CLICK_SYNC_RX_SYNC3_EN
    localparam int N = 3;
`else
    localparam int N = 2;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    click_sync_rx_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
    click_sync_rx #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a word queue plus the delayed view of inR the receiver sees.
    logic [DW-1:0] mq [$];
    logic          m_inA = 1'b0;
    logic          m_hist [N];
    bit            m_fresh = 1'b1;
    logic          m_rs, m_pend, m_rd, m_wr;
    bit            cmp_en = 1'b0;

    always @(posedge clk) begin
        if (!rstn) begin
            mq.delete();
            m_inA   = 1'b0;
            m_fresh = 1'b1;
            for (int i = 0; i < N; i++) m_hist[i] = 1'b0;
        end else begin
            m_rs   = m_hist[N-1];
            m_pend = (m_rs != m_inA);
            m_rd   = (mq.size() != 0) && bus.out_ready;
            m_wr   = m_pend && ((mq.size() < DEPTH) || m_rd);
            if (m_rd) void'(mq.pop_front());
            if (m_wr) begin
                mq.push_back(bus.in_data);
                m_inA   = ~m_inA;
                m_fresh = 1'b0;
            end
            for (int i = N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = bus.inR;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_inA", 64'(bus.inA), 64'(m_inA));
            check("m_out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
            check("m_count", 64'(bus.count), 64'(mq.size()));
            if (mq.size() != 0) begin
                check("m_out_data", 64'(bus.out_data), 64'(mq[0]));
            end else if (m_fresh) begin
                check("m_out_data_rst", 64'(bus.out_data), 64'(0));
            end
        end
    end

    int            toggles = 0;
    int            max_cnt = 0;
    logic          prev_inA = 1'b0;
    logic [DW-1:0] got [$];

    task automatic tick();
        @(posedge clk);
        #2;
        if (bus.inA !== prev_inA) toggles++;
        prev_inA = bus.inA;
        if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    endtask

    // Sender that answers every acknowledge with the next word, for a bounded number of cycles.
    task automatic stream(input int n, input int first, input int cycles);
        int sent;
        sent = 0;
        for (int c = 0; c < cycles; c++) begin
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            if ((bus.inA == bus.inR) && (sent < n)) begin
                bus.inR     = ~bus.inR;
                bus.in_data = DW'(first + sent);
                sent++;
            end
            tick();
        end
    endtask

    initial begin
        int t0;
        bus.inR       = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset held with inR toggling.
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp_en  = 1'b1;
            bus.inR = ~bus.inR;
            check("rst_inA", 64'(bus.inA), 64'(0));
            check("rst_valid", 64'(bus.out_valid), 64'(0));
            check("rst_count", 64'(bus.count), 64'(0));
            check("rst_data", 64'(bus.out_data), 64'(0));
        end
        bus.inR = 1'b0;
        rstn    = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("post_rst_valid", 64'(bus.out_valid), 64'(0));
        check("post_rst_inA", 64'(bus.inA), 64'(0));

        // Single word latency.
        bus.in_data = 32'hA5A5_0001;
        bus.inR     = 1'b1;
        for (int i = 0; i < N; i++) tick();
        check("single_early_inA", 64'(bus.inA), 64'(0));
        check("single_early_valid", 64'(bus.out_valid), 64'(0));
        tick();
        check("single_inA", 64'(bus.inA), 64'(1));
        check("single_valid", 64'(bus.out_valid), 64'(1));
        check("single_count", 64'(bus.count), 64'(1));
        check("single_data", 64'(bus.out_data), 64'h0000_0000_A5A5_0001);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("single_pop_count", 64'(bus.count), 64'(0));
        check("single_pop_valid", 64'(bus.out_valid), 64'(0));

        // Fill and stall with words 1..5.
        t0 = toggles;
        stream(5, 1, 40);
        check("fill_toggles", 64'(toggles - t0), 64'(4));
        check("fill_count", 64'(bus.count), 64'(4));
        check("fill_pending", 64'(bus.inR ^ bus.inA), 64'(1));
        check("fill_head", 64'(bus.out_data), 64'(1));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("r2f_count", 64'(bus.count), 64'(4));
        check("r2f_toggles", 64'(toggles - t0), 64'(5));
        check("r2f_head", 64'(bus.out_data), 64'(2));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        bus.out_ready = 1'b0;
        check("drain_count", 64'(bus.count), 64'(0));

        // Continuous stream across pointer wrap.
        got.delete();
        t0      = toggles;
        max_cnt = 0;
        bus.out_ready = 1'b1;
        stream(10, 1, 60);
        bus.out_ready = 1'b0;
        check("wrap_toggles", 64'(toggles - t0), 64'(10));
        check("wrap_got_n", 64'(got.size()), 64'(10));
        check("wrap_max_count", 64'(max_cnt <= 1), 64'(1));
        for (int i = 0; i < got.size() && i < 10; i++) check("wrap_order", 64'(got[i]), 64'(i + 1));

        // Simultaneous read and write at count 2.
        stream(2, 32'h200, 15);
        check("sim_pre_count", 64'(bus.count), 64'(2));
        t0          = toggles;
        bus.in_data = 32'h0000_0202;
        bus.inR     = ~bus.inR;
        for (int i = 0; i < N; i++) tick();
        check("sim_wait_count", 64'(bus.count), 64'(2));
        check("sim_wait_inA", 64'(toggles - t0), 64'(0));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("sim_count", 64'(bus.count), 64'(2));
        check("sim_head", 64'(bus.out_data), 64'h201);
        check("sim_toggle", 64'(toggles - t0), 64'(1));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.out_ready = 1'b0;
        check("sim_drain", 64'(bus.count), 64'(0));

        // Reset while count is 3 and a request is pending.
        stream(3, 32'h300, 20);
        check("mid_pre_count", 64'(bus.count), 64'(3));
        bus.in_data = 32'h0000_0303;
        bus.inR     = ~bus.inR;
        for (int i = 0; i < N; i++) tick();
        rstn    = 1'b0;
        bus.inR = 1'b0;
        tick();
        check("mid_count", 64'(bus.count), 64'(0));
        check("mid_inA", 64'(bus.inA), 64'(0));
        check("mid_valid", 64'(bus.out_valid), 64'(0));
        check("mid_data", 64'(bus.out_data), 64'(0));
        rstn = 1'b1;
        tick();
        tick();
        check("mid_idle_valid", 64'(bus.out_valid), 64'(0));
        bus.in_data = 32'hC0DE_0042;
        bus.inR     = 1'b1;
        for (int i = 0; i < N + 1; i++) tick();
        check("mid_new_valid", 64'(bus.out_valid), 64'(1));
        check("mid_new_count", 64'(bus.count), 64'(1));
        check("mid_new_data", 64'(bus.out_data), 64'h0000_0000_C0DE_0042);
        check("mid_new_inA", 64'(bus.inA), 64'(1));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("mid_new_pop", 64'(bus.count), 64'(0));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
